pipe_stage_skid: RTL and testbench
==================================

Name: pipe_stage_skid

Overview:
- Parametrised, handshaked pipeline-stage register for the MIPS pipeline. It is the generic successor to the fixed ID/EX register.
- Carries an opaque data payload plus a control field that becomes a bubble on flush.
- A 2-entry skid buffer gives full throughput under back-pressure with a registered in_ready.
- Adds valid tracking, synchronous flush (branch/jump squash) and a saturating stall counter. One instance per stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB).

Parameters:
- DATA_W, 160: payload width (PC4, operands, immediates, register indices). Never zeroed by flush.
- CTRL_W, 16: control-bit width (RegWrite, MemWrite, branch/jump flags, ALUOp). Forced to CTRL_RST on bubble.
- DATA_RST, 160'h0: reset value of out_data. The ID/EX instance sets PC4 bits to 32'h0040_0000.
- CTRL_RST, 16'h0: reset and bubble value of out_ctrl.
- CNT_W, 16: stall-counter width.

Ports:
- clk, input, 1: stage clock. All state updates on the falling edge.
- reset, input, 1: reset, asynchronous, active-low.
- flush, input, 1: synchronous squash of all held beats.
- clr_stats, input, 1: synchronous clear of stall_cnt.
- in_valid, input, 1: upstream beat present.
- in_ready, output, 1: stage can accept. Registered.
- in_data, input, DATA_W: upstream payload.
- in_ctrl, input, CTRL_W: upstream control.
- out_valid, output, 1: head beat present.
- out_ready, input, 1: downstream accepts head.
- out_data, output, DATA_W: head payload.
- out_ctrl, output, CTRL_W: head control, or CTRL_RST when no valid head.
- occupancy, output, 2: beats held (0..2).
- stall_cnt, output, CNT_W: count of stalled edges.

Behaviour:
- Reset (async, reset==0):
  - out_data=DATA_RST, out_ctrl=CTRL_RST.
  - out_valid=0, in_ready=1, occupancy=0, stall_cnt=0, skid entry cleared.
  - Release is synchronous to the next falling edge.
- Storage: main entry (drives out_*) plus skid entry. States EMPTY (occ 0), ONE (occ 1), TWO (occ 2).
- Definitions at each falling edge: acc = in_valid & in_ready; pop = out_valid & out_ready.
- Transitions when flush=0:
  - EMPTY: acc -> ONE, main<=in. No acc -> EMPTY.
  - ONE: acc & !pop -> TWO, skid<=in. acc & pop -> ONE, main<=in. pop only -> EMPTY. Neither -> ONE, hold.
  - TWO: pop -> ONE, main<=skid. No pop -> TWO, hold. acc is impossible here since in_ready=0.
- in_ready is registered: 1 in the edge following any transition into EMPTY or ONE, 0 after entering TWO. There is no combinational in_valid->in_ready or out_ready->in_ready path.
- Latency is 1 edge in->out. Throughput is 1 beat per edge while out_ready=1.
- Ordering is strict FIFO. There is no duplication or loss except on flush.
- out_ctrl = CTRL_RST whenever out_valid=0. It is updated in the same edge the head empties.
- out_data holds its last value when empty.
- Flush (highest priority below reset):
  - Next state EMPTY, out_valid=0, out_ctrl=CTRL_RST, occupancy=0, in_ready=1.
  - An in beat offered the same edge is dropped. A pop the same edge still counts as consumed downstream.
  - out_data is not modified.
- stall_cnt:
  - Increments on each edge with out_valid=1 & out_ready=0.
  - Saturates at 2^CNT_W-1; no wrap.
  - clr_stats zeroes it; if increment coincides, clear wins.
  - flush does not affect it.
- Reset mid-operation discards all held beats immediately, without waiting for clk.
- in_valid while in_ready=0 is ignored. Upstream must hold the beat.
- out_valid/out_data/out_ctrl stay stable while out_valid=1 & out_ready=0.

Test Plan:
- Reset: assert reset=0 mid-stream with occ=2 -> outputs immediately DATA_RST/CTRL_RST, out_valid=0, in_ready=1, occ=0, with no clk edge needed.
- Streaming: 8 beats with in_ctrl=i, out_ready=1 -> out_ctrl 0..7 on consecutive edges, 1 edge latency, occ stays 1.
- Back-pressure: out_ready=0, push beats A, B -> occ=2, in_ready=0 after the 2nd edge, C held upstream. Then out_ready=1 -> A, B, C in order with no gap.
- Flush: occ=2 with ctrl=16'hFFFF, flush=1 plus in_valid=1 beat D -> next edge out_valid=0, out_ctrl=0, D absent. Next beat E emerges normally.
- Stall counter: CNT_W=3, stall 10 edges -> stall_cnt=7 (saturated). clr_stats together with a stall edge -> 0.
- Simultaneous acc & pop in ONE for 4 edges -> occ stays 1, in_ready stays 1, each beat appears exactly once.

Source files
------------

// File: rtl/pipe_stage_skid.sv
// Handshaked pipeline-stage register with a 2-entry skid buffer, flush-to-bubble
// on the control field, and a saturating stall counter. State updates on the falling clock edge.
//
// state | meaning
// EMPTY | no beat held, out_valid=0, out_ctrl=CTRL_RST
// ONE   | head beat in main entry
// TWO   | head in main, next beat in skid, in_ready deasserted
module pipe_stage_skid #(
  parameter int                 DATA_W   = 160,
  parameter int                 CTRL_W   = 16,
  parameter logic [DATA_W-1:0]  DATA_RST = '0,
  parameter logic [CTRL_W-1:0]  CTRL_RST = '0,
  parameter int                 CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              clr_stats,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t            state;
  logic [DATA_W-1:0] main_data;
  logic [CTRL_W-1:0] main_ctrl;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] skid_ctrl;
  logic              rdy_r;
  logic              vld_r;
  logic [CNT_W-1:0]  cnt_r;
  logic              acc;
  logic              pop;

  assign acc = in_valid & rdy_r;
  assign pop = vld_r & out_ready;

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      state     <= EMPTY;
      main_data <= DATA_RST;
      main_ctrl <= CTRL_RST;
      skid_data <= '0;
      skid_ctrl <= '0;
      rdy_r     <= 1'b1;
      vld_r     <= 1'b0;
      cnt_r     <= '0;
    end else begin
      // Clear beats a coincident increment; flush leaves the counter alone.
      if (clr_stats)
        cnt_r <= '0;
      else if (vld_r && !out_ready && cnt_r != CNT_MAX)
        cnt_r <= cnt_r + CNT_W'(1);

      if (flush) begin
        state     <= EMPTY;
        vld_r     <= 1'b0;
        main_ctrl <= CTRL_RST;
        rdy_r     <= 1'b1;
      end else begin
        case (state)
          EMPTY: begin
            if (acc) begin
              state     <= ONE;
              main_data <= in_data;
              main_ctrl <= in_ctrl;
              vld_r     <= 1'b1;
              rdy_r     <= 1'b1;
            end
          end
          ONE: begin
            if (acc && !pop) begin
              state     <= TWO;
              skid_data <= in_data;
              skid_ctrl <= in_ctrl;
              rdy_r     <= 1'b0;
            end else if (acc && pop) begin
              main_data <= in_data;
              main_ctrl <= in_ctrl;
            end else if (pop) begin
              state     <= EMPTY;
              vld_r     <= 1'b0;
              main_ctrl <= CTRL_RST;
              rdy_r     <= 1'b1;
            end
          end
          TWO: begin
            if (pop) begin
              state     <= ONE;
              main_data <= skid_data;
              main_ctrl <= skid_ctrl;
              rdy_r     <= 1'b1;
            end
          end
          default: begin
            state     <= EMPTY;
            vld_r     <= 1'b0;
            main_ctrl <= CTRL_RST;
            rdy_r     <= 1'b1;
          end
        endcase
      end
    end
  end

  assign in_ready  = rdy_r;
  assign out_valid = vld_r;
  assign out_data  = main_data;
  assign out_ctrl  = main_ctrl;
  assign occupancy = state;
  assign stall_cnt = cnt_r;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed vector table, hand sequences for reset and
// stall saturation, then random traffic against a queue-based reference model.
module tb_pipe_stage_skid;
  localparam int DW = 160;
  localparam int CW = 16;
  localparam logic [DW-1:0] DRST = {128'h0, 32'h0040_0000};
  localparam logic [CW-1:0] CRST = 16'h0;

  logic          clk = 1'b1;
  logic          reset, flush, clr_stats, in_valid, out_ready;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_ctrl;
  logic          in_ready, out_valid, in_ready2, out_valid2;
  logic [DW-1:0] out_data, out_data2;
  logic [CW-1:0] out_ctrl, out_ctrl2;
  logic [1:0]    occupancy, occupancy2;
  logic [15:0]   stall_cnt;
  logic [2:0]    stall_cnt2;

  always #5 clk = ~clk;

  pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .DATA_RST(DRST), .CTRL_RST(CRST), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .flush(flush), .clr_stats(clr_stats),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
    .occupancy(occupancy), .stall_cnt(stall_cnt));

  pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .DATA_RST(DRST), .CTRL_RST(CRST), .CNT_W(3)) dut3 (
    .clk(clk), .reset(reset), .flush(flush), .clr_stats(clr_stats),
    .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2), .out_ctrl(out_ctrl2),
    .occupancy(occupancy2), .stall_cnt(stall_cnt2));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: a FIFO of at most two beats.
  typedef struct {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
  } beat_t;
  beat_t         q[$];
  logic [DW-1:0] m_last;
  int            m_stall, m_stall3;

  task automatic model_reset();
    q.delete();
    m_last   = DRST;
    m_stall  = 0;
    m_stall3 = 0;
  endtask

  task automatic model_edge();
    bit ov, ir;
    ov = (q.size() > 0);
    ir = (q.size() < 2);
    if (clr_stats) begin
      m_stall  = 0;
      m_stall3 = 0;
    end else if (ov && !out_ready) begin
      m_stall  = (m_stall  < 65535) ? m_stall + 1 : m_stall;
      m_stall3 = (m_stall3 < 7)     ? m_stall3 + 1 : m_stall3;
    end
    if (flush) q.delete();
    else begin
      if (ov && out_ready) void'(q.pop_front());
      if (in_valid && ir) q.push_back('{d: in_data, c: in_ctrl});
    end
    if (q.size() > 0) m_last = q[0].d;
  endtask

  task automatic check_all(input string tag);
    logic [CW-1:0] ec;
    ec = (q.size() > 0) ? q[0].c : CRST;
    chk({tag, ".out_valid"}, DW'(out_valid), DW'(q.size() > 0));
    chk({tag, ".occupancy"}, DW'(occupancy), DW'(q.size()));
    chk({tag, ".in_ready"},  DW'(in_ready),  DW'(q.size() < 2));
    chk({tag, ".out_ctrl"},  DW'(out_ctrl),  DW'(ec));
    chk({tag, ".out_data"},  out_data,       m_last);
    chk({tag, ".stall_cnt"}, DW'(stall_cnt), DW'(m_stall));
    chk({tag, ".stall3"},    DW'(stall_cnt2), DW'(m_stall3));
    chk({tag, ".out_ctrl3"}, DW'(out_ctrl2), DW'(ec));
  endtask

  task automatic step();
    @(negedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input bit iv, input logic [CW-1:0] c, input bit ordy, input bit fl, input bit clr);
    in_valid  = iv;
    in_ctrl   = c;
    in_data   = {10{c}};
    out_ready = ordy;
    flush     = fl;
    clr_stats = clr;
  endtask

  typedef struct {
    bit            iv;
    logic [CW-1:0] c;
    bit            ordy;
    bit            fl;
    bit            ev;
    logic [CW-1:0] ec;
    logic [1:0]    eocc;
    bit            erdy;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(bit iv, logic [CW-1:0] c, bit ordy, bit fl,
                              bit ev, logic [CW-1:0] ec, logic [1:0] eocc, bit erdy);
    tbl.push_back('{iv: iv, c: c, ordy: ordy, fl: fl, ev: ev, ec: ec, eocc: eocc, erdy: erdy});
  endfunction

  initial begin
    reset = 1'b0;
    drive(0, 16'h0, 0, 0, 0);
    model_reset();
    #12;
    chk("rst.out_valid", DW'(out_valid), DW'(0));
    chk("rst.in_ready",  DW'(in_ready),  DW'(1));
    chk("rst.out_data",  out_data,       DRST);
    chk("rst.occupancy", DW'(occupancy), DW'(0));
    reset = 1'b1;

    // Streaming: 8 beats, one edge latency, simultaneous acc and pop keep occ at 1.
    for (int i = 0; i < 8; i++) add(1, CW'(i), 1, 0, 1, CW'(i), 2'd1, 1);
    add(0, 16'h0, 1, 0, 0, CRST, 2'd0, 1);
    // Back-pressure: A, B fill; C held upstream; then A, B, C drain with no gap.
    add(1, 16'h000A, 0, 0, 1, 16'h000A, 2'd1, 1);
    add(1, 16'h000B, 0, 0, 1, 16'h000A, 2'd2, 0);
    add(1, 16'h000C, 0, 0, 1, 16'h000A, 2'd2, 0);
    add(1, 16'h000C, 1, 0, 1, 16'h000B, 2'd1, 1);
    add(1, 16'h000C, 1, 0, 1, 16'h000C, 2'd1, 1);
    add(0, 16'h0,    1, 0, 0, CRST,     2'd0, 1);
    // Flush from TWO with beat D offered, then E flows normally.
    add(1, 16'hFFFF, 0, 0, 1, 16'hFFFF, 2'd1, 1);
    add(1, 16'hFFFE, 0, 0, 1, 16'hFFFF, 2'd2, 0);
    add(1, 16'h000D, 0, 1, 0, CRST,     2'd0, 1);
    add(1, 16'h000E, 1, 0, 1, 16'h000E, 2'd1, 1);
    add(0, 16'h0,    1, 0, 0, CRST,     2'd0, 1);
    // Flush from ONE while a beat is accepted: the beat is dropped.
    add(1, 16'h0005, 0, 0, 1, 16'h0005, 2'd1, 1);
    add(1, 16'h0006, 0, 1, 0, CRST,     2'd0, 1);
    add(0, 16'h0,    1, 0, 0, CRST,     2'd0, 1);

    foreach (tbl[k]) begin
      drive(tbl[k].iv, tbl[k].c, tbl[k].ordy, tbl[k].fl, 0);
      step();
      chk($sformatf("vec%0d.out_valid", k), DW'(out_valid), DW'(tbl[k].ev));
      chk($sformatf("vec%0d.out_ctrl", k),  DW'(out_ctrl),  DW'(tbl[k].ec));
      chk($sformatf("vec%0d.occupancy", k), DW'(occupancy), DW'(tbl[k].eocc));
      chk($sformatf("vec%0d.in_ready", k),  DW'(in_ready),  DW'(tbl[k].erdy));
      if (tbl[k].ev) chk($sformatf("vec%0d.out_data", k), out_data, {10{tbl[k].ec}});
      check_all($sformatf("vecm%0d", k));
    end

    // Asynchronous reset with two beats held: outputs change without a clock edge.
    drive(1, 16'h0011, 0, 0, 0); step();
    drive(1, 16'h0022, 0, 0, 0); step();
    chk("pre_rst.occupancy", DW'(occupancy), DW'(2));
    drive(0, 16'h0, 0, 0, 0);
    #2;
    reset = 1'b0;
    #1;
    chk("arst.out_valid", DW'(out_valid), DW'(0));
    chk("arst.in_ready",  DW'(in_ready),  DW'(1));
    chk("arst.occupancy", DW'(occupancy), DW'(0));
    chk("arst.out_ctrl",  DW'(out_ctrl),  DW'(CRST));
    chk("arst.out_data",  out_data,       DRST);
    chk("arst.stall_cnt", DW'(stall_cnt), DW'(0));
    #3;
    reset = 1'b1;
    model_reset();

    // Stall saturation on the 3-bit counter, then clear against a stall edge.
    drive(1, 16'h0033, 0, 0, 0); step();
    drive(0, 16'h0, 0, 0, 0);
    for (int i = 0; i < 10; i++) step();
    chk("sat.stall3", DW'(stall_cnt2), DW'(7));
    chk("sat.stall16", DW'(stall_cnt), DW'(10));
    drive(0, 16'h0, 0, 0, 1); step();
    chk("clr.stall3", DW'(stall_cnt2), DW'(0));
    drive(0, 16'h0, 0, 0, 0); step();
    chk("post_clr.stall3", DW'(stall_cnt2), DW'(1));
    check_all("stall_seq");

    // Random traffic against the model.
    for (int i = 0; i < 500; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_ctrl   = CW'($urandom);
      in_data   = {$urandom, $urandom, $urandom, $urandom, $urandom};
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      clr_stats = ($urandom_range(0, 31) == 0);
      step();
      check_all($sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
